// File: rtl/rx_cmd_pkg.sv
// rx_cmd_pkg: shared definitions for the RX command sequencer.
//   - command word bit positions
//   - FSM state constants
//   - settings-bus address offsets of the three burst words
//   - granted-request struct and a chain-lock helper
package rx_cmd_pkg;

    // Command word layout: {send_at, chain, reload, stop, len[27:0]}
    localparam int CMD_SEND_AT = 31;
    localparam int CMD_CHAIN   = 30;
    localparam int CMD_RELOAD  = 29;
    localparam int CMD_STOP    = 28;
    localparam int CMD_LEN_MSB = 27;
    localparam int CMD_LEN_LSB = 0;

    // Burst address offsets relative to BASE
    localparam logic [7:0] OFF_CMD = 8'd0;
    localparam logic [7:0] OFF_THI = 8'd1;
    localparam logic [7:0] OFF_TLO = 8'd2;

    // Sequencer FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_W_CMD = 3'd1;
    localparam logic [2:0] ST_W_THI = 3'd2;
    localparam logic [2:0] ST_W_TLO = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Payload of the requester selected by the arbiter
    typedef struct packed {
        logic [31:0] cmd;
        logic [63:0] tm;
    } cmd_req_t;

    // A chained command keeps the bus for its requester unless it also stops.
    function automatic logic cmd_sets_lock(input logic [31:0] cmd);
        return cmd[CMD_CHAIN] & ~cmd[CMD_STOP];
    endfunction

endpackage

// File: rtl/rx_cmd_rr_arb2.sv
// rx_cmd_rr_arb2: 2-way round-robin arbiter with a chain-lock mask.
//   clk, reset_n   clock, async active-low reset
//   clear          sync clear (last_grant returns to 1)
//   req[1:0]       qualified requests (valid & idle & credit available)
//   chain_locked   only lock_id may be granted while set
//   lock_id        requester owning the lock
//   grant[1:0]     one-hot combinational grant
//   grant_id       index of the granted requester (valid when |grant)
//   last_grant     most recently granted requester
module rx_cmd_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic [1:0] req,
    input  logic       chain_locked,
    input  logic       lock_id,
    output logic [1:0] grant,
    output logic       grant_id,
    output logic       last_grant
);

    logic [1:0] elig;
    logic       last_grant_q;
    logic       last_grant_d;

    always_comb begin
        elig = req;
        if (chain_locked) begin
            elig = lock_id ? {req[1], 1'b0} : {1'b0, req[0]};
        end

        grant    = 2'b00;
        grant_id = 1'b0;
        case (elig)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                // Contention: favour whoever did not win last time.
                grant_id = ~last_grant_q;
                grant    = last_grant_q ? 2'b01 : 2'b10;
            end
            default: ;
        endcase

        last_grant_d = last_grant_q;
        if (clear) begin
            last_grant_d = 1'b1;
        end else if (|grant) begin
            last_grant_d = grant_id;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/rx_cmd_sequencer.sv
// rx_cmd_sequencer: turns timed RX commands from two requesters into atomic
// 3-write settings-bus bursts (cmd, time hi, time lo) followed by one idle
// cycle, with round-robin arbitration, chain locking and a credit counter
// bounding commands outstanding in the RX control command FIFO.
//   clk, reset_n           clock, async active-low reset
//   clear                  sync clear, same effect as reset at next edge
//   reqN_valid/ready       requester handshake (ready is combinational)
//   reqN_cmd, reqN_time    command word and 64-bit command time
//   cmd_done               RX control retired one command
//   set_stb/addr/data      registered settings-bus write
//   credits                free credits
//   busy                   a burst is in progress
//   chain_locked           arbitration locked to one requester
//   credit_err             sticky: cmd_done seen with all credits free
module rx_cmd_sequencer
    import rx_cmd_pkg::*;
#(
    parameter logic [7:0] BASE     = 8'd0,
    parameter int         MAX_CMDS = 8,
    localparam int        CW       = $clog2(MAX_CMDS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [31:0]   req0_cmd,
    input  logic [63:0]   req0_time,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [31:0]   req1_cmd,
    input  logic [63:0]   req1_time,
    input  logic          cmd_done,
    output logic          set_stb,
    output logic [7:0]    set_addr,
    output logic [31:0]   set_data,
    output logic [CW-1:0] credits,
    output logic          busy,
    output logic          chain_locked,
    output logic          credit_err
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_CMDS);

    logic [2:0]    state_q, state_d;
    logic [63:0]   time_q, time_d;
    logic          set_stb_q, set_stb_d;
    logic [7:0]    set_addr_q, set_addr_d;
    logic [31:0]   set_data_q, set_data_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          chain_locked_q, chain_locked_d;
    logic          lock_id_q, lock_id_d;
    logic          credit_err_q, credit_err_d;

    logic [1:0]    arb_req;
    logic [1:0]    grant;
    logic          grant_id;
    logic          last_grant;
    logic          take;
    cmd_req_t      grant_req;

    // Requests only compete while idle, with a credit free, and never in a
    // clear cycle (an acceptance there would be lost by the clear).
    always_comb begin
        arb_req = 2'b00;
        if (state_q == ST_IDLE && credits_q != '0 && !clear) begin
            arb_req = {req1_valid, req0_valid};
        end
    end

    rx_cmd_rr_arb2 u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .req          (arb_req),
        .chain_locked (chain_locked_q),
        .lock_id      (lock_id_q),
        .grant        (grant),
        .grant_id     (grant_id),
        .last_grant   (last_grant)
    );

    assign take       = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign grant_req  = grant_id ? cmd_req_t'{req1_cmd, req1_time}
                                 : cmd_req_t'{req0_cmd, req0_time};

    always_comb begin
        state_d        = state_q;
        time_d         = time_q;
        set_stb_d      = 1'b0;
        set_addr_d     = set_addr_q;
        set_data_d     = set_data_q;
        credits_d      = credits_q;
        chain_locked_d = chain_locked_q;
        lock_id_d      = lock_id_q;
        credit_err_d   = credit_err_q;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    // The cmd word goes straight to the bus register; only
                    // the time needs holding for the next two writes.
                    state_d        = ST_W_CMD;
                    time_d         = grant_req.tm;
                    set_stb_d      = 1'b1;
                    set_addr_d     = BASE + OFF_CMD;
                    set_data_d     = grant_req.cmd;
                    chain_locked_d = cmd_sets_lock(grant_req.cmd);
                    if (cmd_sets_lock(grant_req.cmd)) begin
                        lock_id_d = grant_id;
                    end
                end
            end
            ST_W_CMD: begin
                state_d    = ST_W_THI;
                set_stb_d  = 1'b1;
                set_addr_d = BASE + OFF_THI;
                set_data_d = time_q[63:32];
            end
            ST_W_THI: begin
                state_d    = ST_W_TLO;
                set_stb_d  = 1'b1;
                set_addr_d = BASE + OFF_TLO;
                set_data_d = time_q[31:0];
            end
            ST_W_TLO: state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Grant and retire in the same cycle cancel out.
        if (take && !cmd_done) begin
            credits_d = credits_q - CW'(1);
        end else if (!take && cmd_done) begin
            if (credits_q == MAX_C) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + CW'(1);
            end
        end

        if (clear) begin
            state_d        = ST_IDLE;
            time_d         = '0;
            set_stb_d      = 1'b0;
            set_addr_d     = '0;
            set_data_d     = '0;
            credits_d      = MAX_C;
            chain_locked_d = 1'b0;
            lock_id_d      = 1'b0;
            credit_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            time_q         <= '0;
            set_stb_q      <= 1'b0;
            set_addr_q     <= '0;
            set_data_q     <= '0;
            credits_q      <= MAX_C;
            chain_locked_q <= 1'b0;
            lock_id_q      <= 1'b0;
            credit_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            time_q         <= time_d;
            set_stb_q      <= set_stb_d;
            set_addr_q     <= set_addr_d;
            set_data_q     <= set_data_d;
            credits_q      <= credits_d;
            chain_locked_q <= chain_locked_d;
            lock_id_q      <= lock_id_d;
            credit_err_q   <= credit_err_d;
        end
    end

    assign set_stb      = set_stb_q;
    assign set_addr     = set_addr_q;
    assign set_data     = set_data_q;
    assign credits      = credits_q;
    assign busy         = (state_q != ST_IDLE);
    assign chain_locked = chain_locked_q;
    assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// tb_rx_cmd_sequencer: directed and randomized checks of rx_cmd_sequencer
// against a transaction-level model (credit count, burst countdown, queue of
// expected bus writes).
module tb_rx_cmd_sequencer;

    localparam int         MAXC = 8;
    localparam logic [7:0] BASE = 8'd0;

    logic        clk = 1'b0;
    logic        reset_n, clear, cmd_done;
    logic        v0, v1, r0, r1;
    logic [31:0] c0, c1;
    logic [63:0] t0, t1;
    logic        set_stb, busy, chain_locked, credit_err;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [3:0]  credits;

    always #5 clk = ~clk;

    rx_cmd_sequencer #(.BASE(BASE), .MAX_CMDS(MAXC)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req0_valid(v0), .req0_ready(r0), .req0_cmd(c0), .req0_time(t0),
        .req1_valid(v1), .req1_ready(r1), .req1_cmd(c1), .req1_time(t1),
        .cmd_done(cmd_done), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .credits(credits), .busy(busy),
        .chain_locked(chain_locked), .credit_err(credit_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_credits, m_busy, m_last, m_lock, m_lock_id;
    bit          m_err, m_stb;
    logic [39:0] m_q[$];   // expected writes {addr, data}
    logic [39:0] m_cur;
    bit          obs_r0, obs_r1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credits = MAXC; m_busy = 0; m_last = 1; m_lock = 0; m_lock_id = 0;
        m_err = 0; m_q.delete();
    endtask

    function automatic logic [31:0] rand_plain();
        logic [31:0] r;
        r = $urandom;
        r[30] = 1'b0;
        return r;
    endfunction

    // One clock: check readies before the edge, advance the model, check
    // registered outputs 1 time unit after the edge.
    task automatic cycle(output bit g0, output bit g1);
        bit          e0, e1;
        int          g;
        logic [31:0] cw;
        logic [63:0] tw;
        logic [7:0]  a;
        #2;
        e0 = reset_n && !clear && v0 && m_busy == 0 && m_credits > 0 && (!m_lock || m_lock_id == 0);
        e1 = reset_n && !clear && v1 && m_busy == 0 && m_credits > 0 && (!m_lock || m_lock_id == 1);
        g = -1;
        if (e0 && e1) g = (m_last == 0) ? 1 : 0;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        g0 = (g == 0);
        g1 = (g == 1);
        obs_r0 = r0;
        obs_r1 = r1;
        chk("ready0", r0, g0);
        chk("ready1", r1, g1);
        @(posedge clk);
        #1;
        if (!reset_n || clear) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                cw = (g == 1) ? c1 : c0;
                tw = (g == 1) ? t1 : t0;
                a  = BASE;
                m_q.push_back({a, cw});
                a  = BASE + 8'd1;
                m_q.push_back({a, tw[63:32]});
                a  = BASE + 8'd2;
                m_q.push_back({a, tw[31:0]});
                m_busy = 4;
                m_last = g;
                if (cw[30] && !cw[28]) begin m_lock = 1; m_lock_id = g; end
                else m_lock = 0;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            if (g >= 0 && !cmd_done) m_credits--;
            else if (g < 0 && cmd_done) begin
                if (m_credits == MAXC) m_err = 1;
                else m_credits++;
            end
        end
        if (m_q.size() > 0) begin m_cur = m_q.pop_front(); m_stb = 1; end
        else m_stb = 0;
        chk("set_stb", set_stb, m_stb);
        if (m_stb) begin
            chk("set_addr", set_addr, m_cur[39:32]);
            chk("set_data", set_data, m_cur[31:0]);
        end
        chk("credits", credits, m_credits);
        chk("chain_locked", chain_locked, m_lock);
        chk("credit_err", credit_err, m_err);
        chk("busy", busy, m_busy != 0);
    endtask

    task automatic clear_dut();
        bit g0, g1;
        v0 = 0; v1 = 0; cmd_done = 0; clear = 1;
        cycle(g0, g1);
        clear = 0;
    endtask

    initial begin
        bit g0, g1;
        int seq[$];
        int at[$];
        int stage;

        reset_n = 0; clear = 0; cmd_done = 0;
        v0 = 0; v1 = 0; c0 = '0; c1 = '0; t0 = '0; t1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_stb", set_stb, 0);
        chk("rst_addr", set_addr, 0);
        chk("rst_data", set_data, 0);
        chk("rst_credits", credits, MAXC);
        chk("rst_lock", chain_locked, 0);
        chk("rst_err", credit_err, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1;

        // Single command from req0
        v0 = 1; c0 = 32'h8000_0096; t0 = 64'h100;
        cycle(g0, g1);
        v0 = 0;
        chk("single_ready", obs_r0, 1);
        chk("single_w0_addr", set_addr, 8'h00);
        chk("single_w0_data", set_data, 32'h8000_0096);
        chk("single_credits", credits, 7);
        repeat (5) cycle(g0, g1);

        // Contention: both valid every cycle
        clear_dut();
        v0 = 1; v1 = 1; c0 = rand_plain(); c1 = rand_plain();
        t0 = {$urandom, $urandom}; t1 = {$urandom, $urandom};
        for (int i = 0; i < 20; i++) begin
            cycle(g0, g1);
            if (obs_r0) begin seq.push_back(0); at.push_back(i); c0 = rand_plain(); t0 = {$urandom, $urandom}; end
            if (obs_r1) begin seq.push_back(1); at.push_back(i); c1 = rand_plain(); t1 = {$urandom, $urandom}; end
        end
        v0 = 0; v1 = 0;
        chk("cont_count", seq.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < seq.size()) chk("cont_order", seq[k], k % 2);
        for (int k = 1; k < 4; k++)
            if (k < at.size()) chk("cont_gap", at[k] - at[k-1], 5);
        repeat (5) cycle(g0, g1);

        // Chain lock: req1 chained, then both valid, then req1 stop releases
        clear_dut();
        seq.delete(); stage = 0;
        v1 = 1; c1 = 32'h4000_0001; t1 = 64'h1234_5678_9abc_def0;
        for (int i = 0; i < 20; i++) begin
            cycle(g0, g1);
            if (obs_r1) begin
                seq.push_back(1);
                if (stage == 0) begin c1 = 32'h5000_0002; v0 = 1; c0 = rand_plain(); stage = 1; end
                else v1 = 0;
            end
            if (obs_r0) begin seq.push_back(0); v0 = 0; end
            if (i == 3) chk("chain_locked_mid", chain_locked, 1);
        end
        chk("chain_count", seq.size(), 3);
        if (seq.size() == 3) begin
            chk("chain_g0", seq[0], 1);
            chk("chain_g1", seq[1], 1);
            chk("chain_g2", seq[2], 0);
        end
        chk("chain_released", chain_locked, 0);

        // Credits: exhaust all credits, refill, done coinciding with a grant
        clear_dut();
        v0 = 1; c0 = rand_plain();
        for (int i = 0; i < 48; i++) begin
            cycle(g0, g1);
            if (obs_r0) c0 = rand_plain();
        end
        chk("credits_empty", credits, 0);
        v0 = 0; cmd_done = 1;
        repeat (2) cycle(g0, g1);
        chk("credits_refill", credits, 2);
        v0 = 1;
        cycle(g0, g1);
        cmd_done = 0; v0 = 0;
        chk("done_grant_ready", obs_r0, 1);
        chk("done_grant_credits", credits, 2);
        repeat (5) cycle(g0, g1);

        // Overflow: cmd_done with every credit free
        clear_dut();
        cmd_done = 1;
        cycle(g0, g1);
        cmd_done = 0;
        chk("ovf_err", credit_err, 1);
        chk("ovf_credits", credits, MAXC);
        repeat (3) cycle(g0, g1);
        chk("ovf_sticky", credit_err, 1);

        // Reset, then clear, during W_THI of a chained burst
        for (int pass = 0; pass < 2; pass++) begin
            clear_dut();
            v1 = 1; c1 = 32'h4000_0003; t1 = 64'hAAAA_BBBB_CCCC_DDDD;
            cycle(g0, g1);
            v1 = 0;
            cycle(g0, g1);
            chk("abort_in_thi_addr", set_addr, 8'h01);
            if (pass == 0) reset_n = 0; else clear = 1;
            cycle(g0, g1);
            reset_n = 1; clear = 0;
            chk("abort_stb", set_stb, 0);
            chk("abort_credits", credits, MAXC);
            chk("abort_lock", chain_locked, 0);
            v0 = 1; v1 = 1; c0 = rand_plain(); c1 = rand_plain();
            cycle(g0, g1);
            v0 = 0; v1 = 0;
            chk("abort_next_r0", obs_r0, 1);
            chk("abort_next_r1", obs_r1, 0);
            repeat (5) cycle(g0, g1);
        end

        // Randomized traffic
        clear_dut();
        g0 = 0; g1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (!v0 || g0) begin
                v0 = ($urandom_range(0, 1) == 1);
                c0 = $urandom;
                c0[30] = ($urandom_range(0, 3) == 0);
                t0 = {$urandom, $urandom};
            end
            if (!v1 || g1) begin
                v1 = ($urandom_range(0, 1) == 1);
                c1 = $urandom;
                c1[30] = ($urandom_range(0, 3) == 0);
                t1 = {$urandom, $urandom};
            end
            cmd_done = ($urandom_range(0, 3) == 0);
            cycle(g0, g1);
        end
        cmd_done = 0; v0 = 0; v1 = 0;
        repeat (5) cycle(g0, g1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
